// File: rtl/mcu0_ctrl_fsm_if.sv
// Memory handshake between the mcu0 control sequencer (master) and the shared memory (slave).
interface mcu0_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mcu0_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the mcu0 accumulator datapath.
// Drives all datapath strobes, holds the CMP flags and counts retired instructions.
module mcu0_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  mcu0_ctrl_fsm_if.master   mem,
  input  logic [15:0]       ir,
  input  logic              alu_n,
  input  logic              alu_z,
  output logic              addr_sel,
  output logic              ir_load,
  output logic              pc_load,
  output logic              pc_sel,
  output logic              a_load,
  output logic [3:0]        alu_op,
  output logic              flag_n,
  output logic              flag_z,
  output logic              instr_done,
  output logic [CNT_W-1:0]  retired,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;

  state_t           state_q, state_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;

  logic [3:0] opcode;
  logic       mem_req_c;
  logic       mem_we_c;
  logic       flag_upd;
  logic       unused_operand;

  assign opcode = ir[15:12];
  // The operand address is routed to memory/PC by the datapath, not by this block.
  assign unused_operand = ^ir[11:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      flag_n_q  <= flag_n_d;
      flag_z_q  <= flag_z_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_ADD, OP_ST, OP_CMP: state_d = S_EXEC;
          OP_JMP, OP_JEQ:               state_d = S_FETCH;
          default:                      state_d = S_HALT;
        endcase
      end
      S_EXEC:  if (mem.mem_ready) state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  // Output logic; reset overrides everything so an abandoned access never commits.
  always_comb begin
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = 1'b0;
    a_load     = 1'b0;
    alu_op     = ALU_NOP;
    instr_done = 1'b0;
    flag_upd   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req_c = 1'b1;
          if (mem.mem_ready) begin
            ir_load = 1'b1;
            pc_load = 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_JMP: begin
              pc_load    = 1'b1;
              pc_sel     = 1'b1;
              instr_done = 1'b1;
            end
            OP_JEQ: begin
              pc_load    = flag_z_q;
              pc_sel     = flag_z_q;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          mem_req_c = 1'b1;
          addr_sel  = 1'b1;
          mem_we_c  = (opcode == OP_ST);
          if (opcode == OP_ADD)      alu_op = ALU_ADD;
          else if (opcode == OP_CMP) alu_op = ALU_SUB;
          if (mem.mem_ready) begin
            a_load     = (opcode == OP_LD) || (opcode == OP_ADD);
            flag_upd   = (opcode == OP_CMP);
            instr_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flag_n_d  = flag_upd ? alu_n : flag_n_q;
    flag_z_d  = flag_upd ? alu_z : flag_z_q;
    retired_d = retired_q + CNT_W'(instr_done);
    halted_d  = halted_q || (state_d == S_HALT);
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign flag_n      = flag_n_q;
  assign flag_z      = flag_z_q;
  assign retired     = retired_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_mcu0_ctrl_fsm.sv
// Scoreboard bench for mcu0_ctrl_fsm: expected per-cycle strobe vectors are queued as stimulus is driven.
module tb_mcu0_ctrl_fsm;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [15:0]      ir;
  logic             alu_n, alu_z;
  logic             addr_sel, ir_load, pc_load, pc_sel, a_load;
  logic [3:0]       alu_op;
  logic             flag_n, flag_z, instr_done, halted;
  logic [CNT_W-1:0] retired;

  mcu0_ctrl_fsm_if mif ();

  mcu0_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem        (mif),
    .ir         (ir),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .addr_sel   (addr_sel),
    .ir_load    (ir_load),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .a_load     (a_load),
    .alu_op     (alu_op),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .instr_done (instr_done),
    .retired    (retired),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  logic [11:0]      exp_q[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] m_retired;
  bit               m_fn, m_fz, m_halted;

  // {mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel, a_load, alu_op, instr_done}
  function automatic logic [11:0] vec(bit req, bit we, bit asel, bit irl, bit pcl,
                                      bit pcs, bit al, logic [3:0] op, bit done);
    return {req, we, asel, irl, pcl, pcs, al, op, done};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic step(string tag, bit rst, bit rdy, logic [11:0] e);
    logic [11:0] got;
    logic [11:0] want;
    reset = rst;
    mif.mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clock);
    got  = {mif.mem_req, mif.mem_we, addr_sel, ir_load, pc_load, pc_sel, a_load, alu_op, instr_done};
    want = exp_q.pop_front();
    chk(tag, {20'h0, got}, {20'h0, want});
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(string tag);
    chk({tag, ".retired"}, 32'(retired), 32'(m_retired));
    chk({tag, ".flag_n"},  32'(flag_n),  32'(m_fn));
    chk({tag, ".flag_z"},  32'(flag_z),  32'(m_fz));
    chk({tag, ".halted"},  32'(halted),  32'(m_halted));
  endtask

  task automatic run(string tag, logic [15:0] instr, int fw, int ew, bit n, bit z);
    logic [3:0] op;
    logic [3:0] aop;
    bit we, al;
    op = instr[15:12];
    for (int i = 0; i < fw; i++) step({tag, ".fwait"}, 1'b0, 1'b0, vec(1,0,0,0,0,0,0,4'h0,0));
    step({tag, ".fetch"}, 1'b0, 1'b1, vec(1,0,0,1,1,0,0,4'h0,0));
    ir = instr;
    // mem_ready is held high in DECODE: it must be ignored there.
    case (op)
      4'h2: begin
        step({tag, ".decode"}, 1'b0, 1'b1, vec(0,0,0,0,1,1,0,4'h0,1));
        m_retired++;
      end
      4'h5: begin
        step({tag, ".decode"}, 1'b0, 1'b1, vec(0,0,0,0,m_fz,m_fz,0,4'h0,1));
        m_retired++;
      end
      4'h0, 4'h1, 4'h3, 4'h4: begin
        step({tag, ".decode"}, 1'b0, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
        we  = (op == 4'h3);
        al  = (op == 4'h0) || (op == 4'h1);
        aop = (op == 4'h1) ? 4'h1 : (op == 4'h4) ? 4'h2 : 4'h0;
        alu_n = n;
        alu_z = z;
        for (int i = 0; i < ew; i++) step({tag, ".ewait"}, 1'b0, 1'b0, vec(1,we,1,0,0,0,0,aop,0));
        step({tag, ".exec"}, 1'b0, 1'b1, vec(1,we,1,0,0,0,al,aop,1));
        m_retired++;
        if (op == 4'h4) begin
          m_fn = n;
          m_fz = z;
        end
      end
      default: begin
        step({tag, ".decode"}, 1'b0, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
        m_halted = 1'b1;
      end
    endcase
    check_state(tag);
    $display("instr %s ir=%h retired=%0d flags=%b%b halted=%b", tag, instr, retired, flag_n, flag_z, halted);
  endtask

  initial begin
    logic [CNT_W-1:0] start_cnt;
    reset = 1'b1;
    mif.mem_ready = 1'b0;
    ir = 16'h0000;
    alu_n = 1'b0;
    alu_z = 1'b0;
    m_retired = '0;
    m_fn = 1'b0;
    m_fz = 1'b0;
    m_halted = 1'b0;
    @(posedge clock);
    #1;
    step("reset.init", 1'b1, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
    check_state("reset.init");

    // Straight-line program, zero wait.
    run("ld",  16'h0010, 0, 0, 1'b0, 1'b0);
    run("add", 16'h1012, 0, 0, 1'b0, 1'b0);
    run("st",  16'h3014, 0, 0, 1'b0, 1'b0);

    // CMP then JEQ, taken and not taken.
    run("cmp_z",   16'h4016, 0, 0, 1'b0, 1'b1);
    run("jeq_tk",  16'h5020, 0, 0, 1'b0, 1'b0);
    run("cmp_nz",  16'h4016, 0, 1, 1'b1, 1'b0);
    run("jeq_ntk", 16'h5020, 0, 0, 1'b0, 1'b0);
    run("ld_flag", 16'h0010, 0, 0, 1'b0, 1'b1);

    // Wait states in fetch and exec.
    run("ld_wait",  16'h0018, 3, 2, 1'b0, 1'b0);
    run("st_wait",  16'h301A, 1, 1, 1'b0, 1'b0);

    // Reset held two cycles mid-EXEC of ST with mem_ready high.
    step("rst_st.fetch", 1'b0, 1'b1, vec(1,0,0,1,1,0,0,4'h0,0));
    ir = 16'h3014;
    step("rst_st.decode", 1'b0, 1'b0, vec(0,0,0,0,0,0,0,4'h0,0));
    step("rst_st.r0", 1'b1, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
    step("rst_st.r1", 1'b1, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
    m_retired = '0;
    m_fn = 1'b0;
    m_fz = 1'b0;
    check_state("rst_st");
    step("rst_st.fetch_wait", 1'b0, 1'b0, vec(1,0,0,0,0,0,0,4'h0,0));

    // JMP loop: 16 retires wrap the 4-bit counter back to its start.
    start_cnt = m_retired;
    for (int i = 0; i < 16; i++) run($sformatf("jmp%0d", i), 16'h2000, 0, 0, 1'b0, 1'b0);
    chk("wrap.retired", 32'(retired), 32'(start_cnt));

    // Illegal opcode halts; mem_ready toggling has no effect.
    run("illegal", 16'h7ABC, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("halt%0d", i), 1'b0, i[0], vec(0,0,0,0,0,0,0,4'h0,0));
      chk($sformatf("halt%0d.halted", i), 32'(halted), 32'd1);
      chk($sformatf("halt%0d.retired", i), 32'(retired), 32'(m_retired));
    end
    step("halt.reset", 1'b1, 1'b1, vec(0,0,0,0,0,0,0,4'h0,0));
    m_retired = '0;
    m_fn = 1'b0;
    m_fz = 1'b0;
    m_halted = 1'b0;
    check_state("halt.reset");
    run("after_halt", 16'h0010, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case the bench sequencing ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mcu0_ctrl_fsm.md
# mcu0_ctrl_fsm

Multi-cycle control sequencer for the mcu0 16-bit accumulator datapath (PC, IR, A, ALU, shared byte-addressed memory with 2-byte big-endian words). Replaces the combinational opcode decoder. Steps each instruction through fetch, decode and execute. Holds the CMP status flags and stalls on a memory ready handshake. Emits every load strobe, mux select and ALU opcode the datapath needs, plus a retired-instruction counter for debug.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ir`  in  16  current IR register contents; `ir[15:12]` opcode, `ir[11:0]` operand address C.
- `alu_n`  in  1  sign bit of the ALU result, valid while `alu_op`=SUB.
- `alu_z`  in  1  ALU result == 0, valid while `alu_op`=SUB.
- `mem_ready`  in  1  memory completes the current access this cycle; may be high in the same cycle `mem_req` rises.
- `mem_req`  out  1  memory access in progress.
- `mem_we`  out  1  write, valid with `mem_req`.
- `addr_sel`  out  1  0 = address from PC, 1 = `{4'h0, ir[11:0]}`.
- `ir_load`  out  1  IR captures memory data at the next edge.
- `pc_load`  out  1  PC captures the PC mux output at the next edge.
- `pc_sel`  out  1  0 = PC+2, 1 = `{4'h0, ir[11:0]}`.
- `a_load`  out  1  A captures the ALU output at the next edge.
- `alu_op`  out  4  0 = NOP (pass memory word), 1 = ADD, 2 = SUB.
- `flag_n`, `flag_z`  out  1 each  registered CMP flags.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `retired`  out  CNT_W  count of retired instructions.
- `halted`  out  1  sticky; an illegal opcode was decoded.

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- **FETCH**
  - `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - While `mem_ready`=0, stay in FETCH and assert no strobes.
  - When `mem_ready`=1, assert `ir_load`=1 and `pc_load`=1 with `pc_sel`=0, then go to DECODE.
- **DECODE** (opcode from `ir[15:12]`):
  - LD(0), ADD(1), ST(3), CMP(4): go to EXEC.
  - JMP(2): `pc_load`=1, `pc_sel`=1, retire, go to FETCH.
  - JEQ(5): if `flag_z`=1, `pc_load`=1 and `pc_sel`=1; in either case retire and go to FETCH.
  - Opcodes 6–F: go to HALT. The instruction does not retire.
- **EXEC**
  - `mem_req`=1 and `addr_sel`=1. `mem_we`=1 only for ST.
  - `alu_op`: LD = NOP, ADD = ADD, CMP = SUB, ST = NOP.
  - Wait while `mem_ready`=0. During the wait `alu_op`, `addr_sel` and `mem_we` stay stable and no load strobe is asserted.
  - When `mem_ready`=1:
    - LD/ADD: `a_load`=1.
    - CMP: `flag_n`<=`alu_n` and `flag_z`<=`alu_z`; A is unchanged.
    - ST: the write completes (the datapath drives A onto the memory write data).
    - Then retire and go to FETCH.
- **HALT**
  - All strobes 0 and `mem_req`=0. `halted`=1.
  - Only `reset` exits HALT.
- **Retire**
  - `instr_done`=1 for exactly that cycle, and `retired` increments at the edge.
  - `retired` wraps from all-ones to 0.
- Flags change only on CMP completion. LD, ADD and ST leave them untouched.

## Timing
- Strobes and selects are combinational from state, opcode and `mem_ready`. State, flags, `retired` and `halted` are registered.
- **Reset**
  - While `reset`=1, all strobes are forced to 0, including `mem_req` and `mem_we`. `alu_op`=0.
  - At the edge with `reset`=1: state <= FETCH, `flag_n`=`flag_z`=0, `retired`=0, `halted`=0, `instr_done`=0.
- **Reset mid-instruction:** the instruction is abandoned. No `pc_load`, `a_load` or write occurs in the reset cycle, even if `mem_ready`=1. `reset` overrides every other input.
- **Cycle counts with `mem_ready` held high:**
  - JMP, JEQ: 2 cycles.
  - LD, ADD, ST, CMP: 3 cycles.
  - Each memory wait cycle adds 1.
- **`mem_ready` outside a request:** a `mem_ready` pulse while `mem_req`=0 (DECODE, HALT) is ignored.
- **JEQ flags:** JEQ uses the registered `flag_z`, so a CMP immediately before JEQ is honoured.
- **PC during DECODE:** PC already holds the fetch address + 2 during DECODE. A not-taken JEQ needs no further PC update.
- **`instr_done`:** never asserted on two consecutive cycles.

## Test plan
- **Reset:** hold `reset` 2 cycles mid-EXEC of ST with `mem_ready`=1 → `mem_we`=0 throughout reset; afterwards state FETCH, `retired`=0, flags 0, `halted`=0.
- **Straight-line program, zero wait:** LD 0x010, ADD 0x012, ST 0x014 → FETCH `ir_load`+`pc_load` at cycles 0/3/6; `a_load` at cycles 2 and 5; `mem_we` at cycle 8; `retired`=3 after 9 cycles.
- **Wait states:** `mem_ready` low for 3 cycles in FETCH and 2 in EXEC of LD → LD takes 8 cycles; no strobe during waits; `alu_op`/`addr_sel` constant in EXEC.
- **CMP then JEQ:**
  - CMP with `alu_z`=1, `alu_n`=0, then JEQ 0x020 → `flag_z`=1, `pc_load`+`pc_sel`=1 in JEQ DECODE.
  - Repeat with `alu_z`=0 → no `pc_load` in DECODE; `instr_done` still pulses.
- **JMP loop and counter wrap:** JMP 0x000 looping with `CNT_W`=4 → 2 cycles per instruction; `retired` wraps 15→0 on the 16th retire.
- **Illegal opcode:** `ir`=16'h7ABC → DECODE goes to HALT, `halted`=1, `mem_req`=0, `retired` unchanged; `mem_ready` toggling has no effect; `reset` returns to FETCH with `halted`=0.
